// File: rtl/fir_tap_feeder_if.sv
// rtl/fir_tap_feeder_if.sv - sample stream handshake between a producer and the tap feeder
//
// Signals:
//   in_valid   producer -> feeder  in_sample is presented
//   in_ready   feeder -> producer  feeder accepts this cycle
//   in_sample  producer -> feeder  signed sample, BIT_WIDTH bits
// Modports: master = sample producer, slave = tap feeder.

interface fir_tap_feeder_if #(
  parameter int BIT_WIDTH = 16
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic signed [BIT_WIDTH-1:0] in_sample;

  modport master (output in_valid, output in_sample, input in_ready);
  modport slave  (input in_valid, input in_sample, output in_ready);
endinterface

// File: rtl/fir_tap_feeder.sv
// rtl/fir_tap_feeder.sv - 8-tap delay line, double-buffered coefficients and valid timing for the approximate FIR
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   smp (slave)          sample stream: in_valid / in_ready / in_sample
//   coef_we, coef_addr,  shadow coefficient write
//   coef_data
//   mode_req             requested approximation mode
//   coef_commit          load shadow coefficients and mode_req into the active set
//   flush                drop delay-line contents and restart priming
//   x0..x7               taps, x0 newest, x7 oldest
//   coeff0..coeff7, mode active coefficient set
//   win_valid            x0..x7 form a complete new window this cycle
//   y_valid              filter y_out holds the result of a complete window
//   primed               delay line holds 8 valid samples

module fir_tap_feeder #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  fir_tap_feeder_if.slave             smp,
  input  logic                        coef_we,
  input  logic [2:0]                  coef_addr,
  input  logic signed [BIT_WIDTH-1:0] coef_data,
  input  logic                        mode_req,
  input  logic                        coef_commit,
  input  logic                        flush,
  output logic signed [BIT_WIDTH-1:0] x0,
  output logic signed [BIT_WIDTH-1:0] x1,
  output logic signed [BIT_WIDTH-1:0] x2,
  output logic signed [BIT_WIDTH-1:0] x3,
  output logic signed [BIT_WIDTH-1:0] x4,
  output logic signed [BIT_WIDTH-1:0] x5,
  output logic signed [BIT_WIDTH-1:0] x6,
  output logic signed [BIT_WIDTH-1:0] x7,
  output logic signed [BIT_WIDTH-1:0] coeff0,
  output logic signed [BIT_WIDTH-1:0] coeff1,
  output logic signed [BIT_WIDTH-1:0] coeff2,
  output logic signed [BIT_WIDTH-1:0] coeff3,
  output logic signed [BIT_WIDTH-1:0] coeff4,
  output logic signed [BIT_WIDTH-1:0] coeff5,
  output logic signed [BIT_WIDTH-1:0] coeff6,
  output logic signed [BIT_WIDTH-1:0] coeff7,
  output logic                        mode,
  output logic                        win_valid,
  output logic                        y_valid,
  output logic                        primed
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]                  fill_cnt;
  logic signed [BIT_WIDTH-1:0] taps   [8];
  logic signed [BIT_WIDTH-1:0] shadow [8];
  logic signed [BIT_WIDTH-1:0] active [8];
  logic                        ready;
  logic                        accept;

  // The filter consumes every cycle, so readiness depends only on our own flush handling.
  // flush is folded in combinationally so a same-cycle sample is refused.
  always_comb begin
    ready     = (state != S_FLUSH) && !flush;
    accept    = smp.in_valid && ready;
    state_nxt = state;
    if (flush) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_FILL:  if (accept && (fill_cnt == 4'd7)) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        S_FLUSH: state_nxt = S_FILL;
        default: state_nxt = S_FILL;
      endcase
    end
  end

  assign smp.in_ready = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Delay line, fill counter and valid strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) taps[i] <= '0;
      fill_cnt  <= '0;
      win_valid <= 1'b0;
      y_valid   <= 1'b0;
    end else begin
      if (flush || (state == S_FLUSH)) begin
        for (int i = 0; i < 8; i++) taps[i] <= '0;
        fill_cnt <= '0;
      end else if (accept) begin
        for (int i = 7; i > 0; i--) taps[i] <= taps[i-1];
        taps[0] <= smp.in_sample;
        if (fill_cnt < 4'd8) fill_cnt <= fill_cnt + 4'd1;
      end
      // An accept that leaves 8 samples held completes a window.
      win_valid <= accept && (fill_cnt >= 4'd7);
      // The filter registers y_out one edge after the window is presented.
      y_valid   <= win_valid;
    end
  end

  // Shadow and active coefficient sets; the active set ignores flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      mode <= 1'b0;
    end else begin
      if (coef_we) shadow[coef_addr] <= coef_data;
      if (coef_commit) begin
        // Write-through so a same-cycle write lands in the committed set.
        for (int i = 0; i < 8; i++) begin
          active[i] <= (coef_we && (coef_addr == 3'(i))) ? coef_data : shadow[i];
        end
        mode <= mode_req;
      end
    end
  end

  assign primed = (state == S_RUN);

  assign x0 = taps[0];
  assign x1 = taps[1];
  assign x2 = taps[2];
  assign x3 = taps[3];
  assign x4 = taps[4];
  assign x5 = taps[5];
  assign x6 = taps[6];
  assign x7 = taps[7];

  assign coeff0 = active[0];
  assign coeff1 = active[1];
  assign coeff2 = active[2];
  assign coeff3 = active[3];
  assign coeff4 = active[4];
  assign coeff5 = active[5];
  assign coeff6 = active[6];
  assign coeff7 = active[7];

endmodule
